// File: rtl/seq_display_driver.sv
// Four-digit multiplexed seven-segment driver for a sequence-detector demo:
// shows the detector state, the last sampled Z, and a two-digit BCD detection count.
module seq_display_driver #(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] Q,
    input  logic       Z,
    input  logic       M,
    input  logic       adv,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] det_cnt
);

    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = REFRESH_BITS'(1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment patterns {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    logic [REFRESH_BITS-1:0] r_refresh;
    logic [3:0]              r_ones;
    logic [3:0]              r_tens;
    logic                    r_z;
    logic                    r_m;
    logic                    r_m_valid;
    logic [3:0]              r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;

    logic [1:0] w_sel;
    logic [3:0] w_digit;
    logic       w_blank;
    logic [3:0] w_an_next;
    logic [6:0] w_seg_next;
    logic       w_dp_next;
    logic       w_mode_change;
    logic       w_bump;
    logic [3:0] w_ones_next;
    logic [3:0] w_tens_next;

    assign w_sel = r_refresh[REFRESH_BITS-1 -: 2];

    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        case (w_sel)
            2'd0:    w_digit = {1'b0, Q};
            2'd1:    w_digit = {3'b000, r_z};
            2'd2:    w_digit = r_ones;
            default: begin
                w_digit = r_tens;
                w_blank = (r_tens == 4'd0);
            end
        endcase
    end

    assign w_an_next  = ~(4'b0001 << w_sel);
    assign w_seg_next = w_blank ? SEG_BLANK : seg_encode(w_digit);
    assign w_dp_next  = ~((w_sel == 2'd1) & M);

    // r_m_valid stands in for "registered M equals current M" while in reset,
    // so a mode held across reset release never triggers a spurious clear.
    assign w_mode_change = r_m_valid & (M != r_m);
    assign w_bump        = adv & Z;

    always_comb begin
        w_ones_next = r_ones;
        w_tens_next = r_tens;
        if (w_mode_change) begin
            w_ones_next = 4'd0;
            w_tens_next = 4'd0;
        end else if (w_bump) begin
            if (r_ones >= 4'd9) begin
                w_ones_next = 4'd0;
                w_tens_next = (r_tens >= 4'd9) ? 4'd0 : r_tens + 4'd1;
            end else begin
                w_ones_next = r_ones + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_z       <= 1'b0;
            r_m       <= 1'b0;
            r_m_valid <= 1'b0;
            r_an      <= 4'b1111;
            r_seg     <= SEG_BLANK;
            r_dp      <= 1'b1;
        end else begin
            r_refresh <= r_refresh + REFRESH_ONE;
            r_ones    <= w_ones_next;
            r_tens    <= w_tens_next;
            if (adv) begin
                r_z <= Z;
            end
            r_m       <= M;
            r_m_valid <= 1'b1;
            r_an      <= w_an_next;
            r_seg     <= w_seg_next;
            r_dp      <= w_dp_next;
        end
    end

    assign an      = r_an;
    assign seg     = r_seg;
    assign dp      = r_dp;
    assign det_cnt = {r_tens, r_ones};

endmodule
